// File: rtl/reset_sequencer_pkg.sv
// Shared encodings for the reset sequencer: FSM states, slave addresses, cause bits.
// Pure declarations; no logic.
// No flow control; constants only.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SYS  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic ADDR_STATUS  = 1'b0;
    localparam logic ADDR_CONTROL = 1'b1;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_SW  = 2;

endpackage

// File: rtl/reset_seq_regs.sv
// Slave decode, sticky reset-cause and watchdog-reset counter, registered read mux.
// Read data lags the address by one clock; writes take effect on the next edge.
// No backpressure: every access completes in one cycle, in every sequencer state.
module reset_seq_regs
    import reset_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    input  logic        wdt_trig,
    input  logic        sys_reset_n,
    input  logic        periph_reset_n,
    output logic        sw_req,
    output logic [15:0] readdata
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic             wr_en;
    logic             wr_status;
    logic [2:0]       cause;
    logic [2:0]       cause_set;
    logic [2:0]       cause_clr;
    logic [CNT_W-1:0] wdt_cnt;
    logic [15:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_status    = wr_en & (address == ADDR_STATUS);
    assign sw_req       = wr_en & (address == ADDR_CONTROL) & writedata[0];
    assign unused_wdata = ^writedata[14:3];

    always_comb begin
        cause_set            = 3'b000;
        cause_set[CAUSE_WDT] = wdt_trig;
        cause_set[CAUSE_SW]  = sw_req;
        cause_clr            = wr_status ? writedata[2:0] : 3'b000;
        rd_mux               = (address == ADDR_CONTROL)
                             ? {14'b0, periph_reset_n, sys_reset_n}
                             : {8'(wdt_cnt), 5'b0, cause};
    end

    // Set beats W1C on cause; a watchdog trigger also beats the counter clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause    <= 3'b001;
            wdt_cnt  <= '0;
            readdata <= '0;
        end else begin
            cause    <= (cause & ~cause_clr) | cause_set;
            readdata <= rd_mux;
            if (wdt_trig) begin
                if (wdt_cnt != CNT_SAT)
                    wdt_cnt <= wdt_cnt + CNT_W'(1);
            end else if (wr_status && writedata[15]) begin
                wdt_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Merges POR, watchdog and software resets into a stretched, staged reset pair.
// Outputs drop one edge after a trigger; sys after HOLD_CYCLES, periph PERIPH_DELAY later.
// No backpressure: any trigger, in any state, restarts the hold window.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES  = 16,
    parameter int PERIPH_DELAY = 8,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wdt_resetrequest,
    input  logic        address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        sys_reset_n,
    output logic        periph_reset_n
);

    localparam int CNT_MAX = (HOLD_CYCLES > PERIPH_DELAY) ? HOLD_CYCLES : PERIPH_DELAY;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          wdt_req_d;
    logic          wdt_trig;
    logic          sw_req;
    logic          trigger;

    assign wdt_trig = wdt_resetrequest & ~wdt_req_d;
    assign trigger  = wdt_trig | sw_req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (trigger) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state_nxt = SYS;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                SYS: begin
                    if (cnt == CW'(PERIPH_DELAY - 1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                RUN:     cnt_nxt = '0;
                default: begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they are glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= HOLD;
            cnt            <= '0;
            wdt_req_d      <= 1'b0;
            sys_reset_n    <= 1'b0;
            periph_reset_n <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            wdt_req_d      <= wdt_resetrequest;
            sys_reset_n    <= (state_nxt != HOLD);
            periph_reset_n <= (state_nxt == RUN);
        end
    end

    reset_seq_regs #(
        .CNT_W (CNT_W)
    ) u_regs (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .wdt_trig       (wdt_trig),
        .sys_reset_n    (sys_reset_n),
        .periph_reset_n (periph_reset_n),
        .sw_req         (sw_req),
        .readdata       (readdata)
    );

endmodule
